// File: rtl/vend_input_conditioner.sv
// vend_input_conditioner: input front end for the vending FSM.
// Synchronizes and debounces the four board switches and the sensor button,
// turns the coin code into one fixed-length Coin_insert event per insertion,
// and reports an invalid coin code (11) on Coin_err.
// Optional build macro COIN_TOTAL_EN adds a saturating Coin_total[7:0] output
// that accumulates the value of every accepted coin event.
// The coin FSM state is kept in coin_state_q (typedef coin_state_e) so checkers
// can bind to it hierarchically.
module vend_input_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned PULSE_CYCLES    = 10000000,
   parameter int unsigned CNT_W           = 24
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] SW_raw,
   input  logic       BTN_raw,
   output logic [1:0] Coin_insert,
   output logic       C_A,
   output logic       S_A,
   output logic       BTN_sensor,
   output logic       BTN_rise,
   output logic       Coin_err
`ifdef COIN_TOTAL_EN
   ,
   output logic [7:0] Coin_total
`endif
);

   localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PULSE    = 2'd1,
      WAIT_REL = 2'd2
   } coin_state_e;

   // Bit order everywhere: [1:0] coin code, [2] candy, [3] soda, [4] sensor.
   logic [4:0]            sync1_q, sync1_d;
   logic [4:0]            sync2_q, sync2_d;
   logic [4:0]            stable_q, stable_d;
   logic [4:0][CNT_W-1:0] cnt_q, cnt_d;
   logic                  rise_q, rise_d;

   coin_state_e           coin_state_q, coin_state_d;
   logic [CNT_W-1:0]      pcnt_q, pcnt_d;
   logic [1:0]            code_q, code_d;
   logic [1:0]            coin_q, coin_d;
   logic [1:0]            sc;

`ifdef COIN_TOTAL_EN
   logic [7:0]            total_q, total_d;
   logic [8:0]            total_sum;
`endif

   assign sc = stable_q[1:0];

   // Two-flop synchronizer on all five raw inputs.
   always_comb begin
      sync1_d = {BTN_raw, SW_raw};
      sync2_d = sync1_q;
   end

   // Per-bit debounce: a new synced value must persist DEBOUNCE_CYCLES cycles.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      for (int i = 0; i < 5; i++) begin
         if (sync2_q[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == DEB_LAST) begin
            stable_d[i] = sync2_q[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
      // Rise pulse lines up with the first cycle the stable sensor reads 1.
      rise_d = ~stable_q[4] & stable_d[4];
   end

   // Coin FSM: one fixed-length event per insertion, re-armed only by code 00.
   always_comb begin
      coin_state_d = coin_state_q;
      pcnt_d       = pcnt_q;
      code_d       = code_q;
`ifdef COIN_TOTAL_EN
      total_d      = total_q;
      total_sum    = {1'b0, total_q} + 9'(sc);
`endif
      case (coin_state_q)
         IDLE: begin
            if ((sc == 2'b01) || (sc == 2'b10)) begin
               code_d       = sc;
               pcnt_d       = '0;
               coin_state_d = PULSE;
`ifdef COIN_TOTAL_EN
               total_d      = total_sum[8] ? 8'hFF : total_sum[7:0];
`endif
            end
         end
         PULSE: begin
            // Changes of sc are ignored here; the latched code is held.
            if (pcnt_q == PULSE_LAST) begin
               pcnt_d       = '0;
               coin_state_d = WAIT_REL;
            end else begin
               pcnt_d = pcnt_q + CNT_W'(1);
            end
         end
         WAIT_REL: begin
            if (sc == 2'b00) begin
               coin_state_d = IDLE;
            end
         end
         default: begin
            coin_state_d = IDLE;
         end
      endcase
      // Output register follows the next state so it is high exactly while in PULSE.
      coin_d = (coin_state_d == PULSE) ? code_d : 2'b00;
   end

   // State registers; async active-low reset clears everything.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         stable_q     <= '0;
         cnt_q        <= '0;
         rise_q       <= 1'b0;
         coin_state_q <= IDLE;
         pcnt_q       <= '0;
         code_q       <= 2'b00;
         coin_q       <= 2'b00;
`ifdef COIN_TOTAL_EN
         total_q      <= 8'd0;
`endif
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         stable_q     <= stable_d;
         cnt_q        <= cnt_d;
         rise_q       <= rise_d;
         coin_state_q <= coin_state_d;
         pcnt_q       <= pcnt_d;
         code_q       <= code_d;
         coin_q       <= coin_d;
`ifdef COIN_TOTAL_EN
         total_q      <= total_d;
`endif
      end
   end

   assign Coin_insert = coin_q;
   assign C_A         = stable_q[2];
   assign S_A         = stable_q[3];
   assign BTN_sensor  = stable_q[4];
   assign BTN_rise    = rise_q;
   assign Coin_err    = (stable_q[1:0] == 2'b11);
`ifdef COIN_TOTAL_EN
   assign Coin_total  = total_q;
`endif

endmodule

// File: tb/tb_vend_input_conditioner.sv
// Bench for vend_input_conditioner (DEBOUNCE_CYCLES=4, PULSE_CYCLES=8).
// Build with +define+COIN_TOTAL_EN to include the Coin_total checks.
module tb_vend_input_conditioner;

   localparam int DEB = 4;
   localparam int PUL = 8;

   // ---------------- clock / reset / DUT ----------------
   logic       clk     = 1'b0;
   logic       rst_n   = 1'b1;
   logic [3:0] sw_raw  = 4'b0000;
   logic       btn_raw = 1'b0;
   logic [1:0] coin_insert;
   logic       c_a, s_a, btn_sensor, btn_rise, coin_err;
`ifdef COIN_TOTAL_EN
   logic [7:0] coin_total;
`endif

   always #5 clk = ~clk;

   vend_input_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .PULSE_CYCLES   (PUL),
      .CNT_W          (24)
   ) dut (
      .CLK        (clk),
      .RST        (rst_n),
      .SW_raw     (sw_raw),
      .BTN_raw    (btn_raw),
      .Coin_insert(coin_insert),
      .C_A        (c_a),
      .S_A        (s_a),
      .BTN_sensor (btn_sensor),
      .BTN_rise   (btn_rise),
      .Coin_err   (coin_err)
`ifdef COIN_TOTAL_EN
      ,
      .Coin_total (coin_total)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Observed-event tallies for directed checks.
   int obs_c1   = 0;
   int obs_c2   = 0;
   int obs_rise = 0;
   int obs_ca   = 0;

   // ---------------- reference model ----------------
   // Raw inputs reach the debouncer two edges late; a bit is accepted after
   // DEB consecutive mismatching samples; a coin event is a fixed run of PUL
   // output cycles, and a new event needs a 00 code seen after the last one.
   logic [4:0] raw_hist[$];
   logic [4:0] m_stable;
   int         m_run[5];
   int         m_left;
   bit         m_armed;
   logic [1:0] m_code;
   int         m_total;
   logic       m_rise;
   logic [6:0] exp_q[$];

   function automatic void model_reset();
      raw_hist.delete();
      raw_hist.push_back(5'd0);
      raw_hist.push_back(5'd0);
      m_stable = 5'd0;
      for (int b = 0; b < 5; b++) m_run[b] = 0;
      m_left  = 0;
      m_armed = 1'b1;
      m_code  = 2'b00;
      m_total = 0;
      m_rise  = 1'b0;
   endfunction

   function automatic void push_exp();
      logic [1:0] c;
      c = (m_left > 0) ? m_code : 2'b00;
      exp_q.push_back({c, m_stable[2], m_stable[3], m_stable[4], m_rise,
                       (m_stable[1:0] == 2'b11)});
   endfunction

   function automatic void model_edge();
      logic [4:0] synced;
      logic [4:0] old;
      int         v;
      if (!rst_n) begin
         model_reset();
      end else begin
         synced = raw_hist.pop_front();
         raw_hist.push_back({btn_raw, sw_raw});
         old = m_stable;
         v   = int'(old[1:0]);
         if (m_left > 0) begin
            m_left--;
         end else if (m_armed && (v == 1 || v == 2)) begin
            m_code  = old[1:0];
            m_left  = PUL;
            m_armed = 1'b0;
            m_total = (m_total + v > 255) ? 255 : m_total + v;
         end else if (!m_armed && v == 0) begin
            m_armed = 1'b1;
         end
         for (int b = 0; b < 5; b++) begin
            if (synced[b] != m_stable[b]) begin
               m_run[b]++;
               if (m_run[b] == DEB) begin
                  m_stable[b] = synced[b];
                  m_run[b]    = 0;
               end
            end else begin
               m_run[b] = 0;
            end
         end
         m_rise = ~old[4] & m_stable[4];
      end
      push_exp();
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check_outputs(input string tag);
      logic [6:0] obs;
      logic [6:0] exp;
      obs = {coin_insert, c_a, s_a, btn_sensor, btn_rise, coin_err};
      exp = exp_q.pop_front();
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed={coin,ca,sa,sens,rise,err}=%b expected=%b", tag, obs, exp);
      end
`ifdef COIN_TOTAL_EN
      checks++;
      assert (coin_total === 8'(m_total)) else begin
         errors++;
         $error("FAIL %s_total observed=%0d expected=%0d", tag, coin_total, m_total);
      end
`endif
   endtask

   task automatic check_val(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_outputs(tag);
      if (coin_insert == 2'b01) obs_c1++;
      if (coin_insert == 2'b10) obs_c2++;
      if (btn_rise === 1'b1) obs_rise++;
      if (c_a === 1'b1) obs_ca++;
   endtask

   task automatic hold(input int n, input string tag);
      repeat (n) tick(tag);
   endtask

   // Asserts reset between clock edges and checks the asynchronous clear.
   task automatic async_reset(input string tag);
      rst_n = 1'b0;
      #1;
      model_reset();
      push_exp();
      check_outputs(tag);
   endtask

   task automatic clear_obs();
      obs_c1   = 0;
      obs_c2   = 0;
      obs_rise = 0;
      obs_ca   = 0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed + random stimulus ----------------
   initial begin
      // Reset with all switches on: everything reads 0.
      sw_raw  = 4'b1111;
      btn_raw = 1'b0;
      #1;
      async_reset("reset_clear");
      hold(3, "reset_hold");
      rst_n = 1'b1;
      // Held inputs appear 6 cycles after release.
      hold(5, "reset_release");
      check_val("ca_before_latency", int'(c_a), 0);
      tick("reset_release");
      check_val("ca_at_latency", int'(c_a), 1);
      check_val("sa_at_latency", int'(s_a), 1);
      check_val("coin_err_11", int'(coin_err), 1);
      hold(6, "reset_steady");
      check_val("coin_insert_stays_0", int'(coin_insert), 0);

      // Glitch shorter than the debounce window is swallowed.
      sw_raw = 4'b0000;
      hold(10, "clear");
      clear_obs();
      sw_raw[2] = 1'b1;
      hold(3, "glitch");
      sw_raw[2] = 1'b0;
      hold(10, "glitch_after");
      check_val("glitch_ca_never_high", obs_ca, 0);
      sw_raw[2] = 1'b1;
      hold(10, "candy_long");
      sw_raw[2] = 1'b0;
      hold(12, "candy_release");

      // Single coin event while the switch is held.
      clear_obs();
      sw_raw = 4'b0001;
      hold(100, "coin01_hold");
      check_val("coin01_len", obs_c1, PUL);
      sw_raw = 4'b0000;
      hold(10, "coin_release");
      clear_obs();
      sw_raw = 4'b0010;
      hold(30, "coin10_hold");
      check_val("coin10_len", obs_c2, PUL);
      sw_raw = 4'b0000;
      hold(10, "coin_release");

      // Code changes 01 -> 10 during the pulse: only the first event.
      clear_obs();
      sw_raw = 4'b0001;
      hold(7, "swap_01");
      sw_raw = 4'b0010;
      hold(30, "swap_10");
      check_val("swap_first_len", obs_c1, PUL);
      check_val("swap_no_second", obs_c2, 0);
      sw_raw = 4'b0000;
      hold(20, "swap_release");

      // Invalid code 11.
      clear_obs();
      sw_raw = 4'b0011;
      hold(20, "invalid_11");
      check_val("invalid_err", int'(coin_err), 1);
      check_val("invalid_no_event", obs_c1 + obs_c2, 0);
      sw_raw = 4'b0000;
      hold(10, "invalid_release");

      // Bouncing sensor then steady high: one rise pulse.
      clear_obs();
      for (int k = 0; k < 4; k++) begin
         btn_raw = (k % 2 == 0) ? 1'b1 : 1'b0;
         hold(2, "sensor_bounce");
      end
      btn_raw = 1'b1;
      hold(20, "sensor_steady");
      check_val("sensor_one_rise", obs_rise, 1);
      check_val("sensor_level", int'(btn_sensor), 1);
      btn_raw = 1'b0;
      hold(10, "sensor_release");

      // Reset in the middle of a pulse.
      sw_raw = 4'b0001;
      hold(10, "midpulse");
      check_val("midpulse_active", int'(coin_insert), 1);
      #2;
      async_reset("midpulse_reset");
      check_val("midpulse_coin_zero", int'(coin_insert), 0);
      hold(2, "midpulse_in_reset");
      rst_n = 1'b1;
      hold(20, "midpulse_after");
      sw_raw = 4'b0000;
      hold(10, "midpulse_release");

      // Random segments against the model, with occasional resets.
      for (int s = 0; s < 400; s++) begin
         sw_raw  = 4'($urandom_range(0, 15));
         btn_raw = 1'($urandom_range(0, 1));
         hold($urandom_range(1, 12), "random");
         if ($urandom_range(0, 49) == 0) begin
            #2;
            async_reset("random_reset");
            hold(2, "random_in_reset");
            rst_n = 1'b1;
         end
      end
      sw_raw  = 4'b0000;
      btn_raw = 1'b0;
      hold(20, "random_settle");

`ifdef COIN_TOTAL_EN
      // Saturation of the running coin total.
      #2;
      async_reset("total_reset");
      hold(2, "total_in_reset");
      rst_n = 1'b1;
      hold(10, "total_idle");
      for (int e = 0; e < 130; e++) begin
         sw_raw = 4'b0010;
         hold(16, "total_coin10");
         sw_raw = 4'b0000;
         hold(8, "total_release");
      end
      check_val("total_saturated", int'(coin_total), 255);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
